// File: rtl/invader_controller_pkg.sv
// rtl/invader_controller_pkg.sv - shared invader formation constants
//
// Purpose: geometry of the invader formation shared by the controller, the
// renderer and the collision path. The alive mask is indexed
// row*INVADERS_H + col with row 0 at the top.
// Ports: none (package).
package invader_controller_pkg;

  localparam int INVADERS_H           = 11;  // columns
  localparam int INVADERS_V           = 5;   // rows
  localparam int INVADERS_N           = INVADERS_H * INVADERS_V;
  localparam int INVADERS_OFFSET_H    = 32;  // column pitch, pixels
  localparam int INVADERS_OFFSET_V    = 32;  // row pitch, pixels
  localparam int INVADER_WIDTH_SCALED = 24;  // sprite width after scaling, pixels

  // True when any row still has an invader in column col. The loops compare
  // against constant indices so an out-of-range col simply matches nothing.
  function automatic logic column_alive(input logic [INVADERS_N-1:0] mask,
                                        input logic [3:0]            col);
    logic alive;
    alive = 1'b0;
    for (int r = 0; r < INVADERS_V; r++) begin
      for (int c = 0; c < INVADERS_H; c++) begin
        if (4'(c) == col) begin
          alive = alive | mask[r*INVADERS_H + c];
        end
      end
    end
    return alive;
  endfunction

  // True when any column still has an invader in row row.
  function automatic logic row_alive(input logic [INVADERS_N-1:0] mask,
                                     input logic [3:0]            row);
    logic alive;
    alive = 1'b0;
    for (int r = 0; r < INVADERS_V; r++) begin
      for (int c = 0; c < INVADERS_H; c++) begin
        if (4'(r) == row) begin
          alive = alive | mask[r*INVADERS_H + c];
        end
      end
    end
    return alive;
  endfunction

endpackage

// File: rtl/invader_controller.sv
// rtl/invader_controller.sv - invader formation march, hit bookkeeping and wave end
//
// Purpose: moves the invader formation one step every `period` frame pulses,
// dropping and reversing at the playfield edges, removes invaders on hits,
// speeds the march up as invaders die, and flags wave clear or landing.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, begins a new wave from any state
//   frame           one-cycle pulse at start of blanking
//   hit_valid       hit strobe; hit_index = row*INVADERS_H+col (0..54)
//   invaders        alive mask, bit row*INVADERS_H+col
//   invaders_x/_y   formation top-left origin, pixels
//   step            one-cycle pulse on each horizontal move or drop
//   wave_clear      level, all invaders destroyed
//   landed          level, lowest alive row reached the landing line
module invader_controller
  import invader_controller_pkg::*;
#(
  parameter int STEP_FRAMES   = 32,
  parameter int MIN_FRAMES    = 2,
  parameter int SPEEDUP_KILLS = 5,
  parameter int STEP_X        = 4,
  parameter int STEP_Y        = 16,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 624,
  parameter int X_START       = 64,
  parameter int Y_START       = 48,
  parameter int LAND_Y        = 400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  frame,
  input  logic                  hit_valid,
  input  logic [5:0]            hit_index,
  output logic [INVADERS_N-1:0] invaders,
  output logic [9:0]            invaders_x,
  output logic [9:0]            invaders_y,
  output logic                  step,
  output logic                  wave_clear,
  output logic                  landed
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_MOVE,
    ST_DONE
  } state_t;

  localparam logic [7:0]  STEP_FRAMES_C = 8'(STEP_FRAMES);
  localparam logic [7:0]  MIN_FRAMES_C  = 8'(MIN_FRAMES);
  localparam logic [7:0]  SPEEDUP_C     = 8'(SPEEDUP_KILLS);
  localparam logic [10:0] STEP_X_W      = 11'(STEP_X);
  localparam logic [10:0] X_MIN_W       = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W       = 11'(X_MAX);
  localparam logic [10:0] LAND_Y_W      = 11'(LAND_Y);
  localparam logic [10:0] WIDTH_W       = 11'(INVADER_WIDTH_SCALED);
  localparam logic [9:0]  STEP_X_C      = 10'(STEP_X);
  localparam logic [9:0]  STEP_Y_C      = 10'(STEP_Y);
  localparam logic [9:0]  X_START_C     = 10'(X_START);
  localparam logic [9:0]  Y_START_C     = 10'(Y_START);
  localparam logic [3:0]  LAST_COL      = 4'(INVADERS_H - 1);
  localparam logic [3:0]  ROWS_C        = 4'(INVADERS_V);

  state_t                  state_q, state_d;
  logic [INVADERS_N-1:0]   mask_q, mask_d;
  logic [9:0]              x_q, x_d;
  logic [9:0]              y_q, y_d;
  logic                    dir_left_q, dir_left_d;
  logic [7:0]              period_q, period_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic [7:0]              kill_cnt_q, kill_cnt_d;
  logic [3:0]              scan_k_q, scan_k_d;
  logic [3:0]              colmin_q, colmin_d;
  logic [3:0]              colmax_q, colmax_d;
  logic [2:0]              rowmax_q, rowmax_d;
  logic                    col_found_q, col_found_d;
  logic                    step_q, step_d;
  logic                    wave_clear_q, wave_clear_d;
  logic                    landed_q, landed_d;

  logic                    active;
  logic                    hit_live;
  logic [7:0]              kill_next;
  logic                    col_hit;
  logic                    row_hit;
  logic [10:0]             left_edge;
  logic [10:0]             right_edge;
  logic                    turn;
  logic [9:0]              y_move;
  logic                    land;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_left_d   = dir_left_q;
    period_d     = period_q;
    frame_cnt_d  = frame_cnt_q;
    kill_cnt_d   = kill_cnt_q;
    scan_k_d     = scan_k_q;
    colmin_d     = colmin_q;
    colmax_d     = colmax_q;
    rowmax_d     = rowmax_q;
    col_found_d  = col_found_q;
    step_d       = 1'b0;
    wave_clear_d = wave_clear_q;
    landed_d     = landed_q;
    hit_live     = 1'b0;
    kill_next    = 8'd0;

    active = (state_q == ST_WAIT) || (state_q == ST_SCAN) || (state_q == ST_MOVE);

    // Scan samples the live mask each cycle, so a hit mid-scan is seen by
    // the columns that have not been scanned yet.
    col_hit = column_alive(mask_q, scan_k_q);
    row_hit = (scan_k_q < ROWS_C) && row_alive(mask_q, scan_k_q);

    left_edge  = {1'b0, x_q} + 11'(int'(colmin_q) * INVADERS_OFFSET_H);
    right_edge = {1'b0, x_q} + 11'(int'(colmax_q) * INVADERS_OFFSET_H) + WIDTH_W;
    turn       = dir_left_q ? (left_edge < X_MIN_W + STEP_X_W)
                            : (right_edge + STEP_X_W > X_MAX_W);
    y_move     = turn ? (y_q + STEP_Y_C) : y_q;
    land       = ({1'b0, y_move} + 11'(int'(rowmax_q) * INVADERS_OFFSET_V)) >= LAND_Y_W;

    // Only a hit on a live invader counts; out-of-range indices match no bit.
    if (active && hit_valid) begin
      for (int i = 0; i < INVADERS_N; i++) begin
        if ((6'(i) == hit_index) && mask_q[i]) begin
          hit_live = 1'b1;
        end
      end
    end

    if (hit_live) begin
      for (int i = 0; i < INVADERS_N; i++) begin
        if (6'(i) == hit_index) begin
          mask_d[i] = 1'b0;
        end
      end
      kill_next = kill_cnt_q + 8'd1;
      if (kill_next >= SPEEDUP_C) begin
        kill_cnt_d = 8'd0;
        if (period_q > MIN_FRAMES_C) begin
          period_d = period_q - 8'd1;
        end
      end else begin
        kill_cnt_d = kill_next;
      end
    end

    case (state_q)
      ST_WAIT: begin
        if (frame) begin
          // >= rather than == so a period shortened by a kill never strands
          // the count above it.
          if (frame_cnt_q + 8'd1 >= period_q) begin
            frame_cnt_d = 8'd0;
            scan_k_d    = 4'd0;
            col_found_d = 1'b0;
            colmin_d    = 4'd0;
            colmax_d    = 4'd0;
            rowmax_d    = 3'd0;
            state_d     = ST_SCAN;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      ST_SCAN: begin
        // Columns arrive in ascending order: the first live one is the
        // minimum and the latest live one is the maximum (likewise rows).
        if (col_hit) begin
          if (!col_found_q) begin
            colmin_d = scan_k_q;
          end
          colmax_d    = scan_k_q;
          col_found_d = 1'b1;
        end
        if (row_hit) begin
          rowmax_d = scan_k_q[2:0];
        end
        if (scan_k_q == LAST_COL) begin
          state_d = ST_MOVE;
        end else begin
          scan_k_d = scan_k_q + 4'd1;
        end
      end

      ST_MOVE: begin
        step_d = 1'b1;
        y_d    = y_move;
        if (turn) begin
          dir_left_d = ~dir_left_q;
        end else if (dir_left_q) begin
          x_d = x_q - STEP_X_C;
        end else begin
          x_d = x_q + STEP_X_C;
        end
        landed_d = land;
        state_d  = land ? ST_DONE : ST_WAIT;
      end

      default: ;
    endcase

    // Last invader gone: end the wave and cancel any move in flight.
    if (active && (mask_d == '0)) begin
      state_d      = ST_DONE;
      wave_clear_d = 1'b1;
      step_d       = 1'b0;
      x_d          = x_q;
      y_d          = y_q;
      dir_left_d   = dir_left_q;
      landed_d     = landed_q;
    end

    if (start) begin
      state_d      = ST_WAIT;
      mask_d       = '1;
      x_d          = X_START_C;
      y_d          = Y_START_C;
      dir_left_d   = 1'b0;
      period_d     = STEP_FRAMES_C;
      frame_cnt_d  = 8'd0;
      kill_cnt_d   = 8'd0;
      scan_k_d     = 4'd0;
      col_found_d  = 1'b0;
      step_d       = 1'b0;
      wave_clear_d = 1'b0;
      landed_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      x_q          <= X_START_C;
      y_q          <= Y_START_C;
      dir_left_q   <= 1'b0;
      period_q     <= STEP_FRAMES_C;
      frame_cnt_q  <= 8'd0;
      kill_cnt_q   <= 8'd0;
      scan_k_q     <= 4'd0;
      colmin_q     <= 4'd0;
      colmax_q     <= 4'd0;
      rowmax_q     <= 3'd0;
      col_found_q  <= 1'b0;
      step_q       <= 1'b0;
      wave_clear_q <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_left_q   <= dir_left_d;
      period_q     <= period_d;
      frame_cnt_q  <= frame_cnt_d;
      kill_cnt_q   <= kill_cnt_d;
      scan_k_q     <= scan_k_d;
      colmin_q     <= colmin_d;
      colmax_q     <= colmax_d;
      rowmax_q     <= rowmax_d;
      col_found_q  <= col_found_d;
      step_q       <= step_d;
      wave_clear_q <= wave_clear_d;
      landed_q     <= landed_d;
    end
  end

  assign invaders   = mask_q;
  assign invaders_x = x_q;
  assign invaders_y = y_q;
  assign step       = step_q;
  assign wave_clear = wave_clear_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_invader_controller.sv
// tb/tb_invader_controller.sv - scoreboard bench for invader_controller
module tb_invader_controller;

  localparam logic [54:0] ALL = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, frame_a, hit_valid_a;
  logic [5:0]  hit_index_a;
  logic [54:0] invaders_a;
  logic [9:0]  x_a, y_a;
  logic        step_a, wave_clear_a, landed_a;

  logic        start_b, frame_b, hit_valid_b;
  logic [5:0]  hit_index_b;
  logic [54:0] invaders_b;
  logic [9:0]  x_b, y_b;
  logic        step_b, wave_clear_b, landed_b;

  invader_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a), .frame(frame_a),
    .hit_valid(hit_valid_a), .hit_index(hit_index_a),
    .invaders(invaders_a), .invaders_x(x_a), .invaders_y(y_a),
    .step(step_a), .wave_clear(wave_clear_a), .landed(landed_a)
  );

  // Narrow bounds: the full formation touches both edges, so every step drops.
  invader_controller #(.STEP_FRAMES(3), .MIN_FRAMES(2), .X_MIN(64), .X_MAX(408)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .frame(frame_b),
    .hit_valid(hit_valid_b), .hit_index(hit_index_b),
    .invaders(invaders_b), .invaders_x(x_b), .invaders_y(y_b),
    .step(step_b), .wave_clear(wave_clear_b), .landed(landed_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_a_q[$];
  logic [19:0] exp_b_q[$];
  logic [19:0] ea, eb;

  // Monitors: every step pulse must match a queued {x,y} expectation.
  always @(negedge clk) begin
    if (step_a === 1'b1) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL step_a_unexpected actual x=%0d y=%0d required no step", x_a, y_a);
      end else begin
        ea = exp_a_q.pop_front();
        if ({x_a, y_a} !== ea) begin
          errors++;
          $display("FAIL step_a_pos actual x=%0d y=%0d required x=%0d y=%0d",
                   x_a, y_a, ea[19:10], ea[9:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (step_b === 1'b1) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL step_b_unexpected actual x=%0d y=%0d required no step", x_b, y_b);
      end else begin
        eb = exp_b_q.pop_front();
        if ({x_b, y_b} !== eb) begin
          errors++;
          $display("FAIL step_b_pos actual x=%0d y=%0d required x=%0d y=%0d",
                   x_b, y_b, eb[19:10], eb[9:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_frames(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) frame_b = 1'b1; else frame_a = 1'b1;
      @(negedge clk);
      frame_a = 1'b0;
      frame_b = 1'b0;
    end
  endtask

  task automatic hit(input bit sel, input int idx);
    @(negedge clk);
    if (sel) begin
      hit_valid_b = 1'b1;
      hit_index_b = 6'(idx);
    end else begin
      hit_valid_a = 1'b1;
      hit_index_a = 6'(idx);
    end
    @(negedge clk);
    hit_valid_a = 1'b0;
    hit_valid_b = 1'b0;
  endtask

  // period-1 frames must not step; the period-th must step within the bound.
  task automatic do_step(input bit sel, input int nframes,
                         input logic [9:0] ex, input logic [9:0] ey);
    bit ok;
    int sz;
    send_frames(sel, nframes - 1);
    idle(16);
    if (sel) exp_b_q.push_back({ex, ey}); else exp_a_q.push_back({ex, ey});
    send_frames(sel, 1);
    ok = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sz = sel ? exp_b_q.size() : exp_a_q.size();
      if (sz == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL step_timeout dut=%0d actual no step required x=%0d y=%0d", sel, ex, ey);
      if (sel) exp_b_q.delete(); else exp_a_q.delete();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; frame_a = 1'b0; hit_valid_a = 1'b0; hit_index_a = 6'd0;
    start_b = 1'b0; frame_b = 1'b0; hit_valid_b = 1'b0; hit_index_b = 6'd0;
    idle(3);
    chk("rst_mask", 64'(invaders_a), 64'd0);
    chk("rst_x", 64'(x_a), 64'd64);
    chk("rst_y", 64'(y_a), 64'd48);
    chk("rst_step", 64'(step_a), 64'd0);
    chk("rst_wave_clear", 64'(wave_clear_a), 64'd0);
    chk("rst_landed", 64'(landed_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores frames and hits
    send_frames(0, 40);
    hit(0, 0);
    idle(16);
    chk("idle_mask", 64'(invaders_a), 64'd0);
    chk("idle_x", 64'(x_a), 64'd64);

    pulse_start(0);
    chk("start_mask", 64'(invaders_a), 64'(ALL));
    chk("start_x", 64'(x_a), 64'd64);
    chk("start_y", 64'(y_a), 64'd48);

    do_step(0, 32, 10'd68, 10'd48);

    hit(0, 0);
    hit(0, 0);
    hit(0, 63);
    chk("hit_once_mask", 64'(invaders_a), 64'(ALL & ~55'h1));
    hit(0, 1);
    hit(0, 2);
    hit(0, 3);
    do_step(0, 32, 10'd72, 10'd48);  // four counted kills: period still 32
    hit(0, 4);
    do_step(0, 31, 10'd76, 10'd48);  // fifth kill: period 31
    chk("five_hits_mask", 64'(invaders_a), 64'(ALL & ~55'h1f));

    // 54 kills leave period 22; last invader dies during SCAN
    for (int i = 5; i <= 53; i++) hit(0, i);
    send_frames(0, 22);
    hit(0, 54);
    chk("clear_mask", 64'(invaders_a), 64'd0);
    chk("clear_wave_clear", 64'(wave_clear_a), 64'd1);
    chk("clear_step", 64'(step_a), 64'd0);
    idle(16);
    send_frames(0, 5);
    idle(16);
    chk("done_x", 64'(x_a), 64'd76);
    chk("done_y", 64'(y_a), 64'd48);
    chk("done_wave_clear", 64'(wave_clear_a), 64'd1);
    chk("done_landed", 64'(landed_a), 64'd0);

    // Edge turn and speed floor on the narrow instance
    pulse_start(1);
    chk("b_start_mask", 64'(invaders_b), 64'(ALL));
    do_step(1, 3, 10'd64, 10'd64);   // right edge 408+4 > 408: drop, turn left
    for (int r = 0; r < 5; r++) hit(1, r * 11);
    do_step(1, 2, 10'd60, 10'd64);   // column 0 gone, left edge 96: move left
    for (int r = 0; r < 5; r++) hit(1, r * 11 + 1);
    do_step(1, 2, 10'd56, 10'd64);   // ten kills: period floors at 2
    chk("b_not_landed", 64'(landed_b), 64'd0);

    // Asynchronous reset in the middle of a scan
    send_frames(1, 2);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("scan_rst_mask", 64'(invaders_b), 64'd0);
    chk("scan_rst_x", 64'(x_b), 64'd64);
    chk("scan_rst_y", 64'(y_b), 64'd48);
    chk("scan_rst_step", 64'(step_b), 64'd0);
    chk("scan_rst_wave_clear_a", 64'(wave_clear_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frames(1, 5);
    idle(16);
    chk("post_rst_x", 64'(x_b), 64'd64);

    // Only row 0 alive: drop every step until y reaches 400
    pulse_start(1);
    for (int i = 11; i <= 54; i++) hit(1, i);
    for (int n = 1; n <= 22; n++) begin
      do_step(1, 2, 10'd64, 10'(48 + 16 * n));
      if (n == 21) chk("land_not_yet", 64'(landed_b), 64'd0);
    end
    chk("landed", 64'(landed_b), 64'd1);
    send_frames(1, 6);
    hit(1, 0);
    idle(16);
    chk("landed_hold_y", 64'(y_b), 64'd400);
    chk("landed_hold", 64'(landed_b), 64'd1);
    chk("landed_mask", 64'(invaders_b), 64'h7ff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
